npc_mc_ctrl: RTL and testbench

Multi-cycle sequencing controller for the NPC core, replacing single-cycle combinational flow with an explicit per-instruction FSM.
- Owns PC, instruction register, retired-instruction counter and halt status.
- Drives valid/ready fetch (IFU) and load/store (LSU) request channels, tolerating arbitrary memory wait states.
- Sits between the IFU/LSU bus ports and the existing decode/execute datapath, which reads `inst` and `pc` and returns decode flags, next PC and memory address.

---
 rtl/npc_mc_pkg.sv | 27 ++
 rtl/npc_timeout_cnt.sv | 35 +++
 rtl/npc_mc_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_npc_mc_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npc_mc_pkg.sv
// Shared types and constants for the NPC multi-cycle sequencing controller.
package npc_mc_pkg;

   typedef enum logic [2:0] {
      S_FETCH_REQ  = 3'd0,
      S_FETCH_WAIT = 3'd1,
      S_EXEC       = 3'd2,
      S_MEM_REQ    = 3'd3,
      S_MEM_WAIT   = 3'd4,
      S_WB         = 3'd5,
      S_HALT       = 3'd6
   } state_t;

   localparam logic [1:0] HALT_NONE     = 2'd0;
   localparam logic [1:0] HALT_EBREAK   = 2'd1;
   localparam logic [1:0] HALT_TIMEOUT  = 2'd2;
   localparam logic [1:0] HALT_MISALIGN = 2'd3;

   localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;

   // States in which the controller waits on a bus handshake and is watched by the timeout counter.
   function automatic logic is_timed(input state_t s);
      return (s == S_FETCH_REQ) || (s == S_FETCH_WAIT) ||
             (s == S_MEM_REQ)   || (s == S_MEM_WAIT);
   endfunction

endpackage

// File: rtl/npc_timeout_cnt.sv
// Bus-wait watchdog: counts cycles spent in a waiting state and flags the
// TIMEOUT-th cycle. TIMEOUT=0 disables the flag entirely.
module npc_timeout_cnt #(
   parameter int TIMEOUT = 255,
   parameter int CW      = 8
)(
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_count;

   // clr marks the first cycle of a new waiting state, so the count seen in
   // that cycle is already zero; w_count is the number of cycles completed.
   assign w_count = clr ? '0 : r_cnt;
   assign expired = (TIMEOUT != 0) && en && (w_count == LIMIT);

   // Advance once per enabled cycle, saturating so a disabled timeout never wraps.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (en && (w_count != '1)) begin
         r_cnt <= w_count + CW'(1);
      end else begin
         r_cnt <= w_count;
      end
   end

endmodule

// File: rtl/npc_mc_ctrl.sv
// Multi-cycle per-instruction sequencer for the NPC core: owns PC, IR,
// retired-instruction count and halt status, and drives the IFU/LSU
// valid/ready request channels.
//
//   state      | meaning
//   -----------+-------------------------------------------------------------
//   FETCH_REQ  | alignment check, then hold ifu request until ready
//   FETCH_WAIT | wait for ifu response, latch instruction
//   EXEC       | one cycle with decode flags valid; pick MEM / WB / HALT
//   MEM_REQ    | hold lsu request until ready
//   MEM_WAIT   | wait for load data / store ack
//   WB         | commit pulse, rf write strobe; pc/instret advance on exit
//   HALT       | terminal until reset
module npc_mc_ctrl
   import npc_mc_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
   parameter int              TIMEOUT  = 255,
   parameter int              CNT_W    = 64
)(
   input  logic             clk,
   input  logic             rst,
   output logic             ifu_req_valid,
   input  logic             ifu_req_ready,
   output logic [XLEN-1:0]  ifu_req_addr,
   input  logic             ifu_resp_valid,
   input  logic [31:0]      ifu_resp_data,
   output logic [31:0]      inst,
   output logic [XLEN-1:0]  pc,
   input  logic             dec_is_load,
   input  logic             dec_is_store,
   input  logic             dec_is_ebreak,
   input  logic             dec_rd_wen,
   input  logic [XLEN-1:0]  exu_next_pc,
   input  logic [XLEN-1:0]  exu_mem_addr,
   output logic             lsu_req_valid,
   input  logic             lsu_req_ready,
   output logic             lsu_req_wen,
   output logic [XLEN-1:0]  lsu_req_addr,
   input  logic             lsu_resp_valid,
   output logic             rf_wen,
   output logic             commit,
   output logic [CNT_W-1:0] instret,
   output logic             halted,
   output logic [1:0]       halt_cause
);

   localparam int TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   state_t           r_state;
   logic [XLEN-1:0]  r_pc;
   logic [31:0]      r_inst;
   logic [CNT_W-1:0] r_instret;
   logic             r_ifu_req_valid;
   logic             r_lsu_req_valid;
   logic             r_lsu_req_wen;
   logic [XLEN-1:0]  r_lsu_req_addr;
   logic             r_rf_wen;
   logic             r_commit;
   logic             r_halted;
   logic [1:0]       r_halt_cause;
   logic             r_tmr_clr;

   logic w_is_store;
   logic w_rf_wen_nxt;
   logic w_tmr_en;
   logic w_expired;

   // Load wins when both decode flags are raised.
   assign w_is_store   = dec_is_store & ~dec_is_load;
   assign w_rf_wen_nxt = dec_rd_wen & ~w_is_store;

   // The idle FETCH_REQ cycle (alignment check, no request yet) is not a wait.
   assign w_tmr_en = is_timed(r_state) &&
                     !((r_state == S_FETCH_REQ) && !r_ifu_req_valid);

   npc_timeout_cnt #(
      .TIMEOUT (TIMEOUT),
      .CW      (TO_W)
   ) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clr     (r_tmr_clr),
      .en      (w_tmr_en),
      .expired (w_expired)
   );

   // Instruction sequencing FSM with all bus/strobe outputs registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state         <= S_FETCH_REQ;
         r_pc            <= RESET_PC;
         r_inst          <= '0;
         r_instret       <= '0;
         r_ifu_req_valid <= 1'b0;
         r_lsu_req_valid <= 1'b0;
         r_lsu_req_wen   <= 1'b0;
         r_lsu_req_addr  <= '0;
         r_rf_wen        <= 1'b0;
         r_commit        <= 1'b0;
         r_halted        <= 1'b0;
         r_halt_cause    <= HALT_NONE;
         r_tmr_clr       <= 1'b1;
      end else begin
         r_rf_wen  <= 1'b0;
         r_commit  <= 1'b0;
         r_tmr_clr <= 1'b0;
         case (r_state)
            S_FETCH_REQ: begin
               if (!r_ifu_req_valid) begin
                  if (r_pc[1:0] != 2'b00) begin
                     r_state      <= S_HALT;
                     r_halted     <= 1'b1;
                     r_halt_cause <= HALT_MISALIGN;
                  end else begin
                     r_ifu_req_valid <= 1'b1;
                  end
               end else if (ifu_req_ready) begin
                  r_ifu_req_valid <= 1'b0;
                  r_tmr_clr       <= 1'b1;
                  r_state         <= S_FETCH_WAIT;
               end else if (w_expired) begin
                  r_ifu_req_valid <= 1'b0;
                  r_state         <= S_HALT;
                  r_halted        <= 1'b1;
                  r_halt_cause    <= HALT_TIMEOUT;
               end
            end
            S_FETCH_WAIT: begin
               if (ifu_resp_valid) begin
                  r_inst  <= ifu_resp_data;
                  r_state <= S_EXEC;
               end else if (w_expired) begin
                  r_state      <= S_HALT;
                  r_halted     <= 1'b1;
                  r_halt_cause <= HALT_TIMEOUT;
               end
            end
            S_EXEC: begin
               if (dec_is_ebreak) begin
                  r_state      <= S_HALT;
                  r_halted     <= 1'b1;
                  r_halt_cause <= HALT_EBREAK;
               end else if (dec_is_load || dec_is_store) begin
                  r_lsu_req_valid <= 1'b1;
                  r_lsu_req_wen   <= w_is_store;
                  r_lsu_req_addr  <= exu_mem_addr;
                  r_tmr_clr       <= 1'b1;
                  r_state         <= S_MEM_REQ;
               end else begin
                  r_rf_wen <= w_rf_wen_nxt;
                  r_commit <= 1'b1;
                  r_state  <= S_WB;
               end
            end
            S_MEM_REQ: begin
               if (lsu_req_ready) begin
                  r_lsu_req_valid <= 1'b0;
                  r_tmr_clr       <= 1'b1;
                  r_state         <= S_MEM_WAIT;
               end else if (w_expired) begin
                  r_lsu_req_valid <= 1'b0;
                  r_state         <= S_HALT;
                  r_halted        <= 1'b1;
                  r_halt_cause    <= HALT_TIMEOUT;
               end
            end
            S_MEM_WAIT: begin
               if (lsu_resp_valid) begin
                  r_rf_wen <= w_rf_wen_nxt;
                  r_commit <= 1'b1;
                  r_state  <= S_WB;
               end else if (w_expired) begin
                  r_state      <= S_HALT;
                  r_halted     <= 1'b1;
                  r_halt_cause <= HALT_TIMEOUT;
               end
            end
            S_WB: begin
               // An aligned next PC requests immediately; a misaligned one is
               // caught by the idle FETCH_REQ check without ever raising valid.
               r_pc            <= exu_next_pc;
               r_instret       <= r_instret + CNT_W'(1);
               r_ifu_req_valid <= (exu_next_pc[1:0] == 2'b00);
               r_tmr_clr       <= 1'b1;
               r_state         <= S_FETCH_REQ;
            end
            S_HALT: begin
               r_state <= S_HALT;
            end
            default: begin
               r_ifu_req_valid <= 1'b0;
               r_lsu_req_valid <= 1'b0;
               r_state         <= S_HALT;
               r_halted        <= 1'b1;
            end
         endcase
      end
   end

   assign ifu_req_valid = r_ifu_req_valid;
   assign ifu_req_addr  = r_pc;
   assign inst          = r_inst;
   assign pc            = r_pc;
   assign lsu_req_valid = r_lsu_req_valid;
   assign lsu_req_wen   = r_lsu_req_wen;
   assign lsu_req_addr  = r_lsu_req_addr;
   assign rf_wen        = r_rf_wen;
   assign commit        = r_commit;
   assign instret       = r_instret;
   assign halted        = r_halted;
   assign halt_cause    = r_halt_cause;

endmodule

// File: tb/tb_npc_mc_ctrl.sv
// Directed bench for npc_mc_ctrl. Cycle k is the cycle after the k-th clock
// edge that samples rst low; inputs are driven and outputs sampled 1 time
// unit after each rising edge.
module tb_npc_mc_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        ifu_req_valid;
   logic        ifu_req_ready;
   logic [31:0] ifu_req_addr;
   logic        ifu_resp_valid;
   logic [31:0] ifu_resp_data;
   logic [31:0] inst;
   logic [31:0] pc;
   logic        dec_is_load;
   logic        dec_is_store;
   logic        dec_is_ebreak;
   logic        dec_rd_wen;
   logic [31:0] exu_next_pc;
   logic [31:0] exu_mem_addr;
   logic        lsu_req_valid;
   logic        lsu_req_ready;
   logic        lsu_req_wen;
   logic [31:0] lsu_req_addr;
   logic        lsu_resp_valid;
   logic        rf_wen;
   logic        commit;
   logic [63:0] instret;
   logic        halted;
   logic [1:0]  halt_cause;

   logic [31:0] nxt_inc;
   int          n_checks = 0;
   int          n_err    = 0;

   assign exu_next_pc = pc + nxt_inc;

   always #5 clk = ~clk;

   npc_mc_ctrl #(
      .TIMEOUT (8)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .ifu_req_valid  (ifu_req_valid),
      .ifu_req_ready  (ifu_req_ready),
      .ifu_req_addr   (ifu_req_addr),
      .ifu_resp_valid (ifu_resp_valid),
      .ifu_resp_data  (ifu_resp_data),
      .inst           (inst),
      .pc             (pc),
      .dec_is_load    (dec_is_load),
      .dec_is_store   (dec_is_store),
      .dec_is_ebreak  (dec_is_ebreak),
      .dec_rd_wen     (dec_rd_wen),
      .exu_next_pc    (exu_next_pc),
      .exu_mem_addr   (exu_mem_addr),
      .lsu_req_valid  (lsu_req_valid),
      .lsu_req_ready  (lsu_req_ready),
      .lsu_req_wen    (lsu_req_wen),
      .lsu_req_addr   (lsu_req_addr),
      .lsu_resp_valid (lsu_resp_valid),
      .rf_wen         (rf_wen),
      .commit         (commit),
      .instret        (instret),
      .halted         (halted),
      .halt_cause     (halt_cause)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Leaves the bench in cycle 0 with rst just released.
   task automatic do_reset();
      rst            = 1'b1;
      ifu_req_ready  = 1'b0;
      ifu_resp_valid = 1'b0;
      ifu_resp_data  = 32'h0;
      dec_is_load    = 1'b0;
      dec_is_store   = 1'b0;
      dec_is_ebreak  = 1'b0;
      dec_rd_wen     = 1'b0;
      exu_mem_addr   = 32'h0;
      lsu_req_ready  = 1'b0;
      lsu_resp_valid = 1'b0;
      nxt_inc        = 32'd4;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // ---- reset values, then ALU stream with zero-wait memory ----
      do_reset();
      chk("rst_ifu_valid", ifu_req_valid, 0);
      chk("rst_lsu_valid", lsu_req_valid, 0);
      chk("rst_pc", pc, 32'h8000_0000);
      chk("rst_inst", inst, 0);
      chk("rst_instret", instret, 0);
      chk("rst_halted", halted, 0);
      chk("rst_cause", halt_cause, 0);
      chk("rst_commit", commit, 0);
      chk("rst_rf_wen", rf_wen, 0);

      ifu_req_ready  = 1'b1;
      ifu_resp_valid = 1'b1;
      ifu_resp_data  = 32'h0000_0013;
      dec_rd_wen     = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         tick();
         if (c == 1) chk("alu_first_fetch", ifu_req_valid, 1);
         chk("alu_commit", commit, (c % 4) == 0);
         chk("alu_rf_wen", rf_wen, (c % 4) == 0);
      end
      tick();
      chk("alu_pc", pc, 32'h8000_000C);
      chk("alu_instret", instret, 3);
      chk("alu_fetch_addr", ifu_req_addr, 32'h8000_000C);

      // ---- stalled fetch, then load and store with delayed memory ----
      do_reset();
      for (int c = 1; c <= 6; c++) begin
         tick();
         chk("stall_ifu_valid", ifu_req_valid, 1);
         chk("stall_ifu_addr", ifu_req_addr, 32'h8000_0000);
         if (c == 6) ifu_req_ready = 1'b1;
      end
      tick();                                   // cycle 7: FETCH_WAIT
      chk("stall_wait_entered", ifu_req_valid, 0);
      ifu_req_ready  = 1'b0;
      ifu_resp_valid = 1'b1;
      ifu_resp_data  = 32'h0000_2003;
      dec_is_load    = 1'b1;
      dec_rd_wen     = 1'b1;
      exu_mem_addr   = 32'h8000_1000;
      tick();                                   // cycle 8: EXEC
      chk("ld_inst", inst, 32'h0000_2003);
      ifu_resp_valid = 1'b0;
      tick();                                   // cycle 9: MEM_REQ
      chk("ld_lsu_valid", lsu_req_valid, 1);
      chk("ld_lsu_wen", lsu_req_wen, 0);
      chk("ld_lsu_addr", lsu_req_addr, 32'h8000_1000);
      lsu_req_ready = 1'b1;
      tick();                                   // cycle 10: MEM_WAIT
      chk("ld_lsu_valid_drop", lsu_req_valid, 0);
      lsu_req_ready = 1'b0;
      tick();                                   // cycle 11: still waiting
      chk("ld_no_early_commit", commit, 0);
      lsu_resp_valid = 1'b1;
      tick();                                   // cycle 12: WB
      chk("ld_rf_wen", rf_wen, 1);
      chk("ld_commit", commit, 1);
      lsu_resp_valid = 1'b0;
      tick();                                   // cycle 13: next FETCH_REQ
      chk("ld_pc", pc, 32'h8000_0004);
      chk("ld_instret", instret, 1);
      chk("ld_commit_once", commit, 0);
      ifu_req_ready = 1'b1;
      dec_is_load   = 1'b0;
      dec_is_store  = 1'b1;
      exu_mem_addr  = 32'h8000_2008;
      tick();                                   // cycle 14: FETCH_WAIT
      ifu_req_ready  = 1'b0;
      ifu_resp_valid = 1'b1;
      ifu_resp_data  = 32'h0020_2423;
      tick();                                   // cycle 15: EXEC
      ifu_resp_valid = 1'b0;
      tick();                                   // cycle 16: MEM_REQ
      chk("st_lsu_valid", lsu_req_valid, 1);
      chk("st_lsu_wen", lsu_req_wen, 1);
      chk("st_lsu_addr", lsu_req_addr, 32'h8000_2008);
      lsu_req_ready = 1'b1;
      tick();                                   // cycle 17: MEM_WAIT
      lsu_req_ready  = 1'b0;
      lsu_resp_valid = 1'b1;
      tick();                                   // cycle 18: WB
      chk("st_rf_wen", rf_wen, 0);
      chk("st_commit", commit, 1);
      lsu_resp_valid = 1'b0;
      tick();
      chk("st_instret", instret, 2);
      chk("st_pc", pc, 32'h8000_0008);

      // ---- fetch response never arrives: timeout after 8 wait cycles ----
      do_reset();
      ifu_req_ready = 1'b1;
      tick();                                   // cycle 1: request
      tick();                                   // cycle 2: first FETCH_WAIT cycle
      ifu_req_ready = 1'b0;
      for (int c = 3; c <= 9; c++) tick();      // cycle 9: 8th wait cycle
      chk("to_not_yet", halted, 0);
      tick();                                   // cycle 10
      chk("to_halted", halted, 1);
      chk("to_cause", halt_cause, 2);
      chk("to_ifu_valid", ifu_req_valid, 0);
      chk("to_instret", instret, 0);
      ifu_resp_valid = 1'b1;
      ifu_resp_data  = 32'hDEAD_BEEF;
      tick();
      chk("to_late_resp_ignored", inst, 0);
      chk("to_still_halted", halted, 1);

      // ---- response on the 8th wait cycle wins; it decodes as ebreak ----
      do_reset();
      ifu_req_ready = 1'b1;
      tick();
      tick();
      ifu_req_ready = 1'b0;
      for (int c = 3; c <= 9; c++) tick();      // cycle 9: 8th wait cycle
      ifu_resp_valid = 1'b1;
      ifu_resp_data  = 32'h0010_0073;
      dec_is_ebreak  = 1'b1;
      tick();                                   // cycle 10: EXEC
      chk("edge_no_timeout", halted, 0);
      chk("edge_cause_none", halt_cause, 0);
      chk("edge_inst", inst, 32'h0010_0073);
      ifu_resp_valid = 1'b0;
      tick();                                   // cycle 11: HALT
      chk("ebreak_halted", halted, 1);
      chk("ebreak_cause", halt_cause, 1);
      chk("ebreak_no_commit", commit, 0);
      chk("ebreak_instret", instret, 0);
      tick();
      chk("ebreak_no_late_commit", commit, 0);
      chk("ebreak_ifu_valid", ifu_req_valid, 0);

      // ---- misaligned next PC halts before any request ----
      do_reset();
      nxt_inc        = 32'd2;
      ifu_req_ready  = 1'b1;
      ifu_resp_valid = 1'b1;
      dec_rd_wen     = 1'b1;
      for (int c = 1; c <= 4; c++) tick();
      chk("mis_commit", commit, 1);
      tick();                                   // cycle 5: idle FETCH_REQ
      chk("mis_pc", pc, 32'h8000_0002);
      chk("mis_no_request", ifu_req_valid, 0);
      chk("mis_not_yet", halted, 0);
      tick();                                   // cycle 6: HALT
      chk("mis_halted", halted, 1);
      chk("mis_cause", halt_cause, 3);
      chk("mis_ifu_valid", ifu_req_valid, 0);
      chk("mis_instret", instret, 1);

      // ---- reset asserted while waiting on the LSU ----
      do_reset();
      ifu_req_ready  = 1'b1;
      ifu_resp_valid = 1'b1;
      dec_rd_wen     = 1'b1;
      for (int c = 1; c <= 4; c++) tick();      // ALU instruction commits in cycle 4
      dec_is_load   = 1'b1;
      lsu_req_ready = 1'b1;
      exu_mem_addr  = 32'h8000_3000;
      tick();                                   // cycle 5
      chk("rmid_instret", instret, 1);
      tick();
      tick();
      tick();                                   // cycle 8: MEM_REQ
      chk("rmid_lsu_valid", lsu_req_valid, 1);
      tick();                                   // cycle 9: MEM_WAIT
      chk("rmid_in_wait", lsu_req_valid, 0);
      rst = 1'b1;
      tick();                                   // cycle 10: reset values
      chk("rmid_pc", pc, 32'h8000_0000);
      chk("rmid_instret_clr", instret, 0);
      chk("rmid_ifu_valid", ifu_req_valid, 0);
      chk("rmid_lsu_valid_clr", lsu_req_valid, 0);
      chk("rmid_commit", commit, 0);
      rst = 1'b0;
      tick();
      chk("rmid_refetch", ifu_req_valid, 1);
      chk("rmid_refetch_addr", ifu_req_addr, 32'h8000_0000);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
